// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding
// and load-use bubble insertion.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int FUNCT_WIDTH    = 6,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rt_addr,
  input  logic                      i_id_rs_used,
  input  logic                      i_id_rt_used,
  input  logic [DATA_WIDTH-1:0]     i_id_rs_data,
  input  logic [DATA_WIDTH-1:0]     i_id_rt_data,
  input  logic [DATA_WIDTH-1:0]     i_id_imm,
  input  logic                      i_id_use_imm,
  input  logic [FUNCT_WIDTH-1:0]    i_id_funct,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic                      i_id_reg_write,
  input  logic                      i_id_mem_read,
  input  logic                      i_id_mem_write,
  input  logic                      i_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_result,
  input  logic                      i_wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_result,
  input  logic                      i_hold,
  input  logic                      i_flush,
  output logic                      o_id_stall,
  output logic [DATA_WIDTH-1:0]     o_alu_op_0,
  output logic [DATA_WIDTH-1:0]     o_alu_op_1,
  output logic [FUNCT_WIDTH-1:0]    o_alu_operation,
  output logic                      o_ex_valid,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
  output logic                      o_ex_reg_write,
  output logic                      o_ex_mem_read,
  output logic                      o_ex_mem_write,
  output logic [DATA_WIDTH-1:0]     o_ex_store_data
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic                      rs_used;
    logic                      rt_used;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      use_imm;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t id_d;
  logic   load_use;
  logic   rs_hit;
  logic   rt_hit;
  logic [DATA_WIDTH-1:0] fwd_rs;
  logic [DATA_WIDTH-1:0] fwd_rt;

  // An empty ID slot must not carry side-effecting controls into EX.
  always_comb begin
    id_d           = '0;
    id_d.valid     = i_id_valid;
    id_d.rs_addr   = i_id_rs_addr;
    id_d.rt_addr   = i_id_rt_addr;
    id_d.rs_used   = i_id_rs_used;
    id_d.rt_used   = i_id_rt_used;
    id_d.rs_data   = i_id_rs_data;
    id_d.rt_data   = i_id_rt_data;
    id_d.imm       = i_id_imm;
    id_d.use_imm   = i_id_use_imm;
    id_d.funct     = i_id_funct;
    id_d.rd_addr   = i_id_rd_addr;
    id_d.reg_write = i_id_valid & i_id_reg_write;
    id_d.mem_read  = i_id_valid & i_id_mem_read;
    id_d.mem_write = i_id_valid & i_id_mem_write;
  end

  always_comb begin
    rs_hit   = i_id_rs_used & (i_id_rs_addr == ex_q.rd_addr);
    rt_hit   = i_id_rt_used & (i_id_rt_addr == ex_q.rd_addr);
    load_use = ex_q.valid & ex_q.mem_read
             & (ex_q.rd_addr != '0) & i_id_valid
             & (rs_hit | rt_hit);
  end

  assign o_id_stall = ~i_flush & (i_hold | load_use);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q <= '0;
    end else if (i_flush) begin
      ex_q <= '0;
    end else if (i_hold) begin
      ex_q <= ex_q;
    end else if (load_use) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     data
  );
    logic [DATA_WIDTH-1:0] r;
    r = data;
    if (addr == '0) begin
      r = data;
    end else if (i_mem_reg_write && (i_mem_rd_addr == addr)) begin
      r = i_mem_result;
    end else if (i_wb_reg_write && (i_wb_rd_addr == addr)) begin
      r = i_wb_result;
    end
    return r;
  endfunction

  always_comb begin
    fwd_rs = fwd(ex_q.rs_addr, ex_q.rs_data);
    fwd_rt = fwd(ex_q.rt_addr, ex_q.rt_data);
  end

  assign o_alu_op_0      = fwd_rs;
  assign o_alu_op_1      = ex_q.use_imm ? ex_q.imm : fwd_rt;
  assign o_ex_store_data = fwd_rt;
  assign o_alu_operation = ex_q.funct;
  assign o_ex_valid      = ex_q.valid;
  assign o_ex_rd_addr    = ex_q.rd_addr;
  assign o_ex_reg_write  = ex_q.reg_write;
  assign o_ex_mem_read   = ex_q.mem_read;
  assign o_ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: forwarding,
// load-use bubbles, hold/flush and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        rs_used, rt_used;
  logic [31:0] rs_data, rt_data, imm;
  logic        use_imm;
  logic [5:0]  funct;
  logic        id_rw, id_mr, id_mw;
  logic        mem_rw, wb_rw;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_res, wb_res;
  logic        hold, flush;
  logic        stall;
  logic [31:0] op0, op1, st_data;
  logic [5:0]  alu_op;
  logic        ex_valid, ex_rw, ex_mr, ex_mw;
  logic [4:0]  ex_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs_addr(rs_addr), .i_id_rt_addr(rt_addr),
    .i_id_rs_used(rs_used), .i_id_rt_used(rt_used),
    .i_id_rs_data(rs_data), .i_id_rt_data(rt_data),
    .i_id_imm(imm), .i_id_use_imm(use_imm),
    .i_id_funct(funct), .i_id_rd_addr(rd_addr),
    .i_id_reg_write(id_rw), .i_id_mem_read(id_mr),
    .i_id_mem_write(id_mw),
    .i_mem_reg_write(mem_rw), .i_mem_rd_addr(mem_rd),
    .i_mem_result(mem_res),
    .i_wb_reg_write(wb_rw), .i_wb_rd_addr(wb_rd),
    .i_wb_result(wb_res),
    .i_hold(hold), .i_flush(flush),
    .o_id_stall(stall),
    .o_alu_op_0(op0), .o_alu_op_1(op1),
    .o_alu_operation(alu_op), .o_ex_valid(ex_valid),
    .o_ex_rd_addr(ex_rd), .o_ex_reg_write(ex_rw),
    .o_ex_mem_read(ex_mr), .o_ex_mem_write(ex_mw),
    .o_ex_store_data(st_data)
  );

  typedef struct {
    string       name;
    logic [2:0]  ctl;
    logic        vld;
    logic [4:0]  rs, rt;
    logic [1:0]  used;
    logic [31:0] rsd, rtd, imm;
    logic        ui;
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        e_stall, e_valid;
    logic [31:0] e_op0, e_op1, e_st;
    logic [5:0]  e_fn;
    logic [4:0]  e_rd;
    logic [2:0]  e_ctrl;
  } vec_t;

  vec_t vq[$];

  // ctl={rst,hold,flush} used={rs,rt} ctrl={rw,mr,mw}
  function automatic vec_t mk(
    string nm, logic [2:0] ctl,
    logic vld, logic [4:0] rs, logic [4:0] rt, logic [1:0] used,
    logic [31:0] rsd, logic [31:0] rtd, logic [31:0] im,
    logic ui, logic [5:0] fn, logic [4:0] rd, logic [2:0] ctrl,
    logic mrw, logic [4:0] mrd, logic [31:0] mres,
    logic wrw, logic [4:0] wrd, logic [31:0] wres,
    logic e_stall, logic e_valid,
    logic [31:0] e_op0, logic [31:0] e_op1, logic [31:0] e_st,
    logic [5:0] e_fn, logic [4:0] e_rd, logic [2:0] e_ctrl
  );
    vec_t v;
    v.name = nm; v.ctl = ctl; v.vld = vld;
    v.rs = rs; v.rt = rt; v.used = used;
    v.rsd = rsd; v.rtd = rtd; v.imm = im; v.ui = ui;
    v.fn = fn; v.rd = rd; v.ctrl = ctrl;
    v.mrw = mrw; v.mrd = mrd; v.mres = mres;
    v.wrw = wrw; v.wrd = wrd; v.wres = wres;
    v.e_stall = e_stall; v.e_valid = e_valid;
    v.e_op0 = e_op0; v.e_op1 = e_op1; v.e_st = e_st;
    v.e_fn = e_fn; v.e_rd = e_rd; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    {rst, hold, flush} = v.ctl;
    id_valid = v.vld;
    rs_addr = v.rs; rt_addr = v.rt;
    {rs_used, rt_used} = v.used;
    rs_data = v.rsd; rt_data = v.rtd;
    imm = v.imm; use_imm = v.ui;
    funct = v.fn; rd_addr = v.rd;
    {id_rw, id_mr, id_mw} = v.ctrl;
    mem_rw = v.mrw; mem_rd = v.mrd; mem_res = v.mres;
    wb_rw = v.wrw; wb_rd = v.wrd; wb_res = v.wres;
  endtask

  task automatic chk_ex(string nm, vec_t v);
    chk({nm, ".valid"}, 32'(ex_valid), 32'(v.e_valid));
    chk({nm, ".op0"}, op0, v.e_op0);
    chk({nm, ".op1"}, op1, v.e_op1);
    chk({nm, ".store"}, st_data, v.e_st);
    chk({nm, ".funct"}, 32'(alu_op), 32'(v.e_fn));
    chk({nm, ".rd"}, 32'(ex_rd), 32'(v.e_rd));
    chk({nm, ".ctrl"}, 32'({ex_rw, ex_mr, ex_mw}), 32'(v.e_ctrl));
  endtask

  initial begin
    vec_t z;
    // Table: expected EX values are those seen just after the edge.
    vq.push_back(mk("add", 3'b000,
      1, 3, 4, 2'b11, 5, 7, 0, 0, 6'h20, 5, 3'b100,
      0, 0, 0, 0, 0, 0,
      0, 1, 5, 7, 7, 6'h20, 5, 3'b100));
    vq.push_back(mk("fwd_mem", 3'b000,
      1, 8, 0, 2'b10, 1, 2, 0, 0, 6'h22, 6, 3'b100,
      1, 8, 'h11, 1, 8, 'h22,
      0, 1, 'h11, 2, 2, 6'h22, 6, 3'b100));
    vq.push_back(mk("fwd_wb", 3'b010,
      1, 8, 0, 2'b10, 1, 2, 0, 0, 6'h22, 6, 3'b100,
      0, 8, 'h11, 1, 8, 'h22,
      1, 1, 'h22, 2, 2, 6'h22, 6, 3'b100));
    vq.push_back(mk("fwd_none", 3'b010,
      1, 8, 0, 2'b10, 1, 2, 0, 0, 6'h22, 6, 3'b100,
      1, 9, 'h33, 1, 7, 'h44,
      1, 1, 1, 2, 2, 6'h22, 6, 3'b100));
    vq.push_back(mk("fwd_r0", 3'b000,
      1, 0, 0, 2'b11, 'h99, 'h77, 0, 0, 6'h20, 7, 3'b100,
      1, 0, 'h11, 1, 0, 'h22,
      0, 1, 'h99, 'h77, 'h77, 6'h20, 7, 3'b100));
    vq.push_back(mk("lw", 3'b000,
      1, 2, 9, 2'b10, 'h100, 0, 4, 1, 6'h20, 9, 3'b110,
      0, 0, 0, 0, 0, 0,
      0, 1, 'h100, 4, 0, 6'h20, 9, 3'b110));
    vq.push_back(mk("lu_stall", 3'b000,
      1, 1, 9, 2'b11, 'h10, 'hDEAD, 0, 0, 6'h20, 10, 3'b100,
      1, 9, 'hBAD, 0, 0, 0,
      1, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk("lu_enter", 3'b000,
      1, 1, 9, 2'b11, 'h10, 'hDEAD, 0, 0, 6'h20, 10, 3'b100,
      0, 0, 0, 1, 9, 'hABCD,
      0, 1, 'h10, 'hABCD, 'hABCD, 6'h20, 10, 3'b100));
    vq.push_back(mk("sw_imm", 3'b000,
      1, 1, 5, 2'b11, 'h200, 1, 'h10, 1, 6'h20, 0, 3'b001,
      1, 5, 'h55, 0, 0, 0,
      0, 1, 'h200, 'h10, 'h55, 6'h20, 0, 3'b001));
    vq.push_back(mk("id_invalid", 3'b000,
      0, 3, 4, 2'b11, 'hA, 'hB, 0, 0, 6'h22, 11, 3'b111,
      0, 0, 0, 0, 0, 0,
      0, 0, 'hA, 'hB, 'hB, 6'h22, 11, 3'b000));
    vq.push_back(mk("lw_r0", 3'b000,
      1, 2, 0, 2'b10, 'h300, 0, 8, 1, 6'h20, 0, 3'b110,
      0, 0, 0, 0, 0, 0,
      0, 1, 'h300, 8, 0, 6'h20, 0, 3'b110));
    vq.push_back(mk("nolu_r0", 3'b000,
      1, 0, 0, 2'b11, 5, 6, 0, 0, 6'h20, 12, 3'b100,
      0, 0, 0, 0, 0, 0,
      0, 1, 5, 6, 6, 6'h20, 12, 3'b100));
    vq.push_back(mk("lw_b", 3'b000,
      1, 2, 9, 2'b10, 'h400, 0, 0, 1, 6'h20, 9, 3'b110,
      0, 0, 0, 0, 0, 0,
      0, 1, 'h400, 0, 0, 6'h20, 9, 3'b110));
    vq.push_back(mk("nolu_unused", 3'b000,
      1, 9, 9, 2'b00, 1, 2, 7, 1, 6'h20, 13, 3'b100,
      0, 0, 0, 0, 0, 0,
      0, 1, 1, 7, 2, 6'h20, 13, 3'b100));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("hold", 3'b010,
        1, 1, 2, 2'b11, 'hF0, 'hF1, 0, 0, 6'h22, 14, 3'b100,
        0, 0, 0, 0, 0, 0,
        1, 1, 1, 7, 2, 6'h20, 13, 3'b100));
    vq.push_back(mk("flush_hold", 3'b011,
      1, 1, 2, 2'b11, 'hF0, 'hF1, 0, 0, 6'h22, 14, 3'b100,
      0, 0, 0, 0, 0, 0,
      0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk("lw_c", 3'b000,
      1, 2, 9, 2'b10, 'h500, 0, 0, 1, 6'h20, 9, 3'b110,
      0, 0, 0, 0, 0, 0,
      0, 1, 'h500, 0, 0, 6'h20, 9, 3'b110));
    vq.push_back(mk("flush_lu", 3'b001,
      1, 9, 3, 2'b11, 1, 2, 0, 0, 6'h20, 14, 3'b100,
      0, 0, 0, 0, 0, 0,
      0, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk("lw_d", 3'b000,
      1, 2, 9, 2'b10, 'h500, 0, 0, 1, 6'h20, 9, 3'b110,
      0, 0, 0, 0, 0, 0,
      0, 1, 'h500, 0, 0, 6'h20, 9, 3'b110));
    vq.push_back(mk("lu_rs", 3'b000,
      1, 9, 3, 2'b11, 1, 2, 0, 0, 6'h20, 14, 3'b100,
      0, 0, 0, 0, 0, 0,
      1, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk("lw_e", 3'b000,
      1, 2, 9, 2'b10, 'h500, 0, 0, 1, 6'h20, 9, 3'b110,
      0, 0, 0, 0, 0, 0,
      0, 1, 'h500, 0, 0, 6'h20, 9, 3'b110));
    vq.push_back(mk("rst_stall", 3'b100,
      1, 9, 3, 2'b11, 1, 2, 0, 0, 6'h20, 14, 3'b100,
      0, 0, 0, 0, 0, 0,
      1, 0, 0, 0, 0, 0, 0, 3'b000));
    vq.push_back(mk("after_rst", 3'b000,
      1, 9, 3, 2'b11, 1, 2, 0, 0, 6'h20, 14, 3'b100,
      0, 0, 0, 1, 9, 'hABCD,
      0, 1, 'hABCD, 2, 2, 6'h20, 14, 3'b100));

    // Reset under random inputs.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      id_valid = 1'($urandom); rs_addr = 5'($urandom);
      rt_addr = 5'($urandom); rs_used = 1'($urandom);
      rt_used = 1'($urandom); rs_data = $urandom;
      rt_data = $urandom; imm = $urandom;
      use_imm = 1'($urandom); funct = 6'($urandom);
      rd_addr = 5'($urandom); id_rw = 1'($urandom);
      id_mr = 1'($urandom); id_mw = 1'($urandom);
      mem_rw = 1'b1; mem_rd = 5'($urandom); mem_res = $urandom;
      wb_rw = 1'b1; wb_rd = 5'($urandom); wb_res = $urandom;
      hold = 1'($urandom); flush = 1'($urandom);
      @(posedge clk);
      #1;
      z = mk("", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_ex("reset", z);
      @(negedge clk);
    end
    drive(z);
    #1;
    chk("reset.stall", 32'(stall), 0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk({vq[i].name, ".stall"}, 32'(stall), 32'(vq[i].e_stall));
      @(posedge clk);
      #1;
      chk_ex(vq[i].name, vq[i]);
    end

    // Hold with a load-use pending: stall stays high, EX frozen.
    @(negedge clk);
    drive(vq[5]);
    @(posedge clk);
    @(negedge clk);
    drive(vq[6]);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hold_lu.stall", 32'(stall), 1);
      @(posedge clk);
      #1;
      chk("hold_lu.mr", 32'(ex_mr), 1);
      chk("hold_lu.rd", 32'(ex_rd), 9);
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    chk("unhold_lu.stall", 32'(stall), 1);
    @(posedge clk);
    #1;
    chk("unhold_lu.bubble", 32'(ex_valid), 0);
    @(negedge clk);
    #1;
    chk("unhold_lu.release", 32'(stall), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS core, directly upstream of the ALU.
- Captures decoded instruction fields from ID once per cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and asks ID to stall while it inserts a bubble.
- Drives the ALU operand and operation inputs for the instruction currently in EX.

## Interface
- DATA_WIDTH, 32, operand/result width
- FUNCT_WIDTH, 6, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs_addr, i_id_rt_addr  in  REG_ADDR_WIDTH  source register indices
- i_id_rs_used, i_id_rt_used  in  1  instruction reads rs / rt
- i_id_rs_data, i_id_rt_data  in  DATA_WIDTH  register file read data
- i_id_imm  in  DATA_WIDTH  immediate, already extended by ID
- i_id_use_imm  in  1  ALU operand 1 is the immediate
- i_id_funct  in  FUNCT_WIDTH  ALU operation
- i_id_rd_addr  in  REG_ADDR_WIDTH  destination register
- i_id_reg_write, i_id_mem_read, i_id_mem_write  in  1  destination write, load, store
- i_mem_reg_write  in  1  MEM stage writes a register
- i_mem_rd_addr  in  REG_ADDR_WIDTH  MEM stage destination
- i_mem_result  in  DATA_WIDTH  MEM stage result
- i_wb_reg_write  in  1  WB stage writes a register
- i_wb_rd_addr  in  REG_ADDR_WIDTH  WB stage destination
- i_wb_result  in  DATA_WIDTH  WB stage result
- i_hold  in  1  downstream freeze
- i_flush  in  1  kill the instruction in EX and the instruction in ID
- o_id_stall  out  1  ID must hold its instruction this cycle
- o_alu_op_0, o_alu_op_1  out  DATA_WIDTH  ALU operands
- o_alu_operation  out  FUNCT_WIDTH  ALU operation
- o_ex_valid  out  1  EX holds a real instruction
- o_ex_rd_addr  out  REG_ADDR_WIDTH  destination register, passed to MEM
- o_ex_reg_write, o_ex_mem_read, o_ex_mem_write  out  1  controls, passed to MEM
- o_ex_store_data  out  DATA_WIDTH  forwarded rt value, used as store data

## Operation
- EX register contents: valid, rs/rt addr, rs/rt used, rs/rt data, imm, use_imm, funct, rd, reg_write, mem_read, mem_write.
- Register update on posedge i_clk, priority order:
  - i_rst: all fields cleared to 0.
  - i_flush: bubble. Valid, reg_write, mem_read and mem_write go to 0; other fields are don't-care, cleared to 0.
  - i_hold: all fields keep their value.
  - load_use: bubble.
  - Otherwise: capture the ID fields. If i_id_valid=0, valid, reg_write, mem_read and mem_write are captured as 0.
- load_use = o_ex_valid & o_ex_mem_read & (o_ex_rd_addr != 0) & i_id_valid & ((i_id_rs_used & rs_addr == o_ex_rd_addr) | (i_id_rt_used & rt_addr == o_ex_rd_addr)).
- o_id_stall = !i_flush & (i_hold | load_use). This output is combinational.
- Forwarding is combinational and applies to rs and rt independently, using the EX copies of addr and data:
  - Addr 0 is never forwarded; the register data is used.
  - Else if i_mem_reg_write and i_mem_rd_addr == addr: use i_mem_result. MEM has priority over WB.
  - Else if i_wb_reg_write and i_wb_rd_addr == addr: use i_wb_result.
  - Else use the captured register data.
- Operand and control outputs:
  - o_alu_op_0 = fwd_rs.
  - o_alu_op_1 = use_imm ? imm : fwd_rt.
  - o_ex_store_data = fwd_rt, regardless of use_imm.
  - o_alu_operation = captured funct.
- MEM-stage load results are never forwarded from i_mem_result; the load-use bubble guarantees the value arrives through WB.

## Timing
- Latency: an instruction presented in ID at cycle N appears on the EX outputs in cycle N+1.
- Load-use: exactly one bubble per hazard. The stalled ID instruction enters EX at N+2 and takes the load value through the WB forward.
- Reset values: all outputs are 0 in the cycle after i_rst, including o_id_stall and both ALU operands.
- Reset applied mid-stall clears the pending hazard. o_id_stall drops once the EX load is gone.
- Flush together with hold: flush wins and EX becomes a bubble.
- Flush together with load_use: bubble, and o_id_stall=0. ID is being flushed by its own control.
- Hold with forwarding: MEM and WB are also frozen under i_hold, so the forwarded values stay stable.
- The WB forward covers the case where the register file reads and writes the same register in one cycle; this block adds no extra bypass for it.

## Test plan
- Reset: assert i_rst with random inputs → all outputs 0 the next cycle; o_ex_valid=0.
- Pass-through: ADD with rs=3 (data 5), rt=4 (data 7), no hazards → next cycle o_alu_op_0=5, o_alu_op_1=7, o_ex_reg_write=1.
- Forward priority: EX rs=8; MEM writes r8=0x11 and WB writes r8=0x22 → o_alu_op_0=0x11. Drop the MEM write → 0x22. Set rs=0 with both writing r0 → register data.
- Load-use: LW r9 in EX, next ID instruction reads rt=r9:
  - o_id_stall=1 for one cycle, then a bubble (o_ex_valid=0).
  - Instruction enters EX at N+2 with op_1 = i_wb_result (0xABCD).
- Immediate and store: SW with use_imm=1, imm=0x10, rt forwarded from MEM=0x55 → o_alu_op_1=0x10, o_ex_store_data=0x55.
- Hold/flush: i_hold for 3 cycles → EX outputs frozen, o_id_stall=1. Assert i_flush together with i_hold → o_ex_valid=0 next cycle and o_id_stall=0.
